// File: rtl/vpipe_pkg.sv
// Shared vpipe definitions: default address/data widths and the store-buffer depth check.
package vpipe_pkg;

    localparam int VP_AW    = 8;
    localparam int VP_DW    = 8;
    localparam int VP_DEPTH = 4;

    // Pointers wrap naturally, so the depth must be a power of two and at least 2.
    function automatic bit vp_depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    localparam bit VP_DEPTH_OK = vp_depth_ok(VP_DEPTH);

endpackage

// File: rtl/vpipe_sb_fwd.sv
// Store-to-load forwarding search over the occupied store-buffer entries; youngest match wins.
module vpipe_sb_fwd #(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]    valid,
    input  logic [DEPTH*AW-1:0] addr_flat,
    input  logic [DEPTH*DW-1:0] data_flat,
    input  logic [PW-1:0]       head,
    input  logic [PW:0]         count,
    input  logic [AW-1:0]       raddr,
    output logic                hit,
    output logic [DW-1:0]       hit_data
);

    logic [PW-1:0] idx;

    // Walk oldest to youngest; each later match overrides, so the youngest has priority.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (((PW+1)'(i) < count) && valid[idx] &&
                (addr_flat[idx*AW +: AW] == raddr)) begin
                hit      = 1'b1;
                hit_data = data_flat[idx*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/vpipe_store_buffer.sv
// In-order store buffer between the vpipe core and memory, with load forwarding.
module vpipe_store_buffer
    import vpipe_pkg::*;
#(
    parameter int AW    = VP_AW,
    parameter int DW    = VP_DW,
    parameter int DEPTH = VP_DEPTH,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_wen,
    input  logic [AW-1:0] in_waddr,
    input  logic [DW-1:0] in_wdata,
    output logic          in_ready,
    input  logic          in_ren,
    input  logic [AW-1:0] in_raddr,
    output logic [DW-1:0] in_rdata,
    output logic          mem_wen,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_wready,
    output logic          mem_ren,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic [PW:0]   count,
    output logic          empty
);

    if (!vp_depth_ok(DEPTH)) begin : g_bad_depth
        $error("vpipe_store_buffer: DEPTH must be a power of two and >= 2");
    end

    logic [AW-1:0]       addr_q [DEPTH];
    logic [DW-1:0]       data_q [DEPTH];
    logic [DEPTH-1:0]    valid_q;
    logic [PW-1:0]       head_q;
    logic [PW-1:0]       tail_q;
    logic [PW:0]         count_q;
    logic                enq;
    logic                deq;
    logic [DEPTH*AW-1:0] addr_flat;
    logic [DEPTH*DW-1:0] data_flat;
    logic                hit;
    logic [DW-1:0]       hit_data;

    assign in_ready  = (count_q != (PW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign mem_wen   = !empty;
    assign mem_waddr = addr_q[head_q];
    assign mem_wdata = data_q[head_q];
    assign enq       = in_wen && in_ready;
    assign deq       = mem_wen && mem_wready;

    // Entry payload carries no reset; valid/count define what is meaningful.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= in_waddr;
            data_q[tail_q] <= in_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (enq) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (deq) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign addr_flat[g*AW +: AW] = addr_q[g];
        assign data_flat[g*DW +: DW] = data_q[g];
    end

    // Search sees registered state only, so a same-cycle write is never forwarded.
    vpipe_sb_fwd #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fwd (
        .valid     (valid_q),
        .addr_flat (addr_flat),
        .data_flat (data_flat),
        .head      (head_q),
        .count     (count_q),
        .raddr     (in_raddr),
        .hit       (hit),
        .hit_data  (hit_data)
    );

    assign mem_raddr = in_raddr;
    assign mem_ren   = in_ren && !hit;
    assign in_rdata  = !in_ren ? '0 : (hit ? hit_data : mem_rdata);

endmodule

// File: tb/tb_vpipe_store_buffer.sv
// Directed bench for vpipe_store_buffer: vector table plus wrap-around and reset sequences.
module tb_vpipe_store_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_wen;
    logic [7:0] in_waddr;
    logic [7:0] in_wdata;
    logic       in_ready;
    logic       in_ren;
    logic [7:0] in_raddr;
    logic [7:0] in_rdata;
    logic       mem_wen;
    logic [7:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       mem_wready;
    logic       mem_ren;
    logic [7:0] mem_raddr;
    logic [7:0] mem_rdata;
    logic [2:0] count;
    logic       empty;

    int checks = 0;
    int errors = 0;
    int proto_errs = 0;

    always #5 clk = ~clk;

    vpipe_store_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .in_wen     (in_wen),
        .in_waddr   (in_waddr),
        .in_wdata   (in_wdata),
        .in_ready   (in_ready),
        .in_ren     (in_ren),
        .in_raddr   (in_raddr),
        .in_rdata   (in_rdata),
        .mem_wen    (mem_wen),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wready (mem_wready),
        .mem_ren    (mem_ren),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .count      (count),
        .empty      (empty)
    );

    typedef struct {
        string      name;
        logic       wen;
        logic [7:0] wa;
        logic [7:0] wd;
        logic       ren;
        logic [7:0] ra;
        logic [7:0] mrd;
        logic       mwr;
        logic [2:0] e_count;
        logic       e_rdy;
        logic       e_mwen;
        logic [7:0] e_wa;
        logic [7:0] e_wd;
        logic [7:0] e_rd;
        logic       e_mren;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic wen, logic [7:0] wa, logic [7:0] wd,
                                logic ren, logic [7:0] ra, logic [7:0] mrd, logic mwr,
                                logic [2:0] e_count, logic e_rdy, logic e_mwen,
                                logic [7:0] e_wa, logic [7:0] e_wd, logic [7:0] e_rd,
                                logic e_mren);
        vec_t v;
        v.name = name; v.wen = wen; v.wa = wa; v.wd = wd; v.ren = ren; v.ra = ra;
        v.mrd = mrd; v.mwr = mwr; v.e_count = e_count; v.e_rdy = e_rdy;
        v.e_mwen = e_mwen; v.e_wa = e_wa; v.e_wd = e_wd; v.e_rd = e_rd; v.e_mren = e_mren;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wen, input logic [7:0] wa, input logic [7:0] wd,
                         input logic ren, input logic [7:0] ra, input logic [7:0] mrd,
                         input logic mwr);
        in_wen = wen; in_waddr = wa; in_wdata = wd;
        in_ren = ren; in_raddr = ra; mem_rdata = mrd; mem_wready = mwr;
    endtask

    task automatic note_protocol;
        if (in_wen && !in_ready) begin
            proto_errs++;
            $display("protocol: write to 0x%0h while buffer full was dropped", in_waddr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];

        // idle after reset
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk("idle", 0,8'h00,8'h00, 0,8'h00,8'h00, 0, 0,1,0,8'h00,8'h00,8'h00,0));
        // single entry, held then drained
        vecs.push_back(mk("w10",     1,8'h10,8'hAA, 0,8'h00,8'hEE, 0, 0,1,0,8'h00,8'h00,8'h00,0));
        vecs.push_back(mk("hold10",  0,8'h00,8'h00, 1,8'h10,8'hEE, 0, 1,1,1,8'h10,8'hAA,8'hAA,0));
        vecs.push_back(mk("drain10", 0,8'h00,8'h00, 1,8'h10,8'hEE, 1, 1,1,1,8'h10,8'hAA,8'hAA,0));
        vecs.push_back(mk("empty10", 0,8'h00,8'h00, 0,8'h00,8'h00, 0, 0,1,0,8'h00,8'h00,8'h00,0));
        // fill to full, refused writes, in-order drain
        vecs.push_back(mk("w01",     1,8'h01,8'h11, 0,8'h00,8'h00, 0, 0,1,0,8'h00,8'h00,8'h00,0));
        vecs.push_back(mk("w02",     1,8'h02,8'h12, 0,8'h00,8'h00, 0, 1,1,1,8'h01,8'h11,8'h00,0));
        vecs.push_back(mk("w03",     1,8'h03,8'h13, 0,8'h00,8'h00, 0, 2,1,1,8'h01,8'h11,8'h00,0));
        vecs.push_back(mk("w04",     1,8'h04,8'h14, 0,8'h00,8'h00, 0, 3,1,1,8'h01,8'h11,8'h00,0));
        vecs.push_back(mk("w05full", 1,8'h05,8'h15, 0,8'h00,8'h00, 0, 4,0,1,8'h01,8'h11,8'h00,0));
        vecs.push_back(mk("holdfull",0,8'h00,8'h00, 0,8'h00,8'h00, 0, 4,0,1,8'h01,8'h11,8'h00,0));
        vecs.push_back(mk("w06deq",  1,8'h06,8'h16, 0,8'h00,8'h00, 1, 4,0,1,8'h01,8'h11,8'h00,0));
        vecs.push_back(mk("d02",     0,8'h00,8'h00, 0,8'h00,8'h00, 1, 3,1,1,8'h02,8'h12,8'h00,0));
        vecs.push_back(mk("d03",     0,8'h00,8'h00, 0,8'h00,8'h00, 1, 2,1,1,8'h03,8'h13,8'h00,0));
        vecs.push_back(mk("d04r05",  0,8'h00,8'h00, 1,8'h05,8'h5A, 1, 1,1,1,8'h04,8'h14,8'h5A,1));
        vecs.push_back(mk("empty04", 1,8'h20,8'h05, 0,8'h00,8'h00, 0, 0,1,0,8'h00,8'h00,8'h00,0));
        // forwarding: youngest wins, miss, no read, same-cycle write not forwarded
        vecs.push_back(mk("w20b",    1,8'h20,8'h07, 0,8'h00,8'h00, 0, 1,1,1,8'h20,8'h05,8'h00,0));
        vecs.push_back(mk("r20",     0,8'h00,8'h00, 1,8'h20,8'hEE, 0, 2,1,1,8'h20,8'h05,8'h07,0));
        vecs.push_back(mk("r21",     0,8'h00,8'h00, 1,8'h21,8'h3C, 0, 2,1,1,8'h20,8'h05,8'h3C,1));
        vecs.push_back(mk("noren",   0,8'h00,8'h00, 0,8'h20,8'h3C, 0, 2,1,1,8'h20,8'h05,8'h00,0));
        vecs.push_back(mk("w22r22",  1,8'h22,8'h99, 1,8'h22,8'h44, 0, 2,1,1,8'h20,8'h05,8'h44,1));
        vecs.push_back(mk("r22",     0,8'h00,8'h00, 1,8'h22,8'hEE, 0, 3,1,1,8'h20,8'h05,8'h99,0));
        vecs.push_back(mk("dq20a",   0,8'h00,8'h00, 1,8'h20,8'hEE, 1, 3,1,1,8'h20,8'h05,8'h07,0));
        vecs.push_back(mk("dq20b",   0,8'h00,8'h00, 1,8'h20,8'hEE, 1, 2,1,1,8'h20,8'h07,8'h07,0));
        vecs.push_back(mk("dq22",    0,8'h00,8'h00, 1,8'h20,8'h11, 1, 1,1,1,8'h22,8'h99,8'h11,1));
        vecs.push_back(mk("emptyf",  0,8'h00,8'h00, 0,8'h00,8'h00, 0, 0,1,0,8'h00,8'h00,8'h00,0));

        rst = 1'b1;
        drive(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].wen, vecs[i].wa, vecs[i].wd, vecs[i].ren, vecs[i].ra,
                  vecs[i].mrd, vecs[i].mwr);
            #1;
            chk({vecs[i].name, ".count"},    32'(count),    32'(vecs[i].e_count));
            chk({vecs[i].name, ".empty"},    32'(empty),    32'(vecs[i].e_count == 3'd0));
            chk({vecs[i].name, ".in_ready"}, 32'(in_ready), 32'(vecs[i].e_rdy));
            chk({vecs[i].name, ".mem_wen"},  32'(mem_wen),  32'(vecs[i].e_mwen));
            if (vecs[i].e_mwen) begin
                chk({vecs[i].name, ".mem_waddr"}, 32'(mem_waddr), 32'(vecs[i].e_wa));
                chk({vecs[i].name, ".mem_wdata"}, 32'(mem_wdata), 32'(vecs[i].e_wd));
            end
            chk({vecs[i].name, ".in_rdata"},  32'(in_rdata),  32'(vecs[i].e_rd));
            chk({vecs[i].name, ".mem_ren"},   32'(mem_ren),   32'(vecs[i].e_mren));
            chk({vecs[i].name, ".mem_raddr"}, 32'(mem_raddr), 32'(vecs[i].ra));
            note_protocol();
            @(posedge clk);
            @(negedge clk);
        end

        // three entries held, then ten cycles of simultaneous enqueue/dequeue across wrap
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h30 + 8'(i), 8'h60 + 8'(i), 0, 8'h00, 8'h00, 0);
            q.push_back(8'h30 + 8'(i));
            @(posedge clk);
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 8'h33 + 8'(i), 8'h63 + 8'(i), 0, 8'h00, 8'h00, 1);
            #1;
            chk("wrap.count",     32'(count),     32'd3);
            chk("wrap.in_ready",  32'(in_ready),  32'd1);
            chk("wrap.mem_waddr", 32'(mem_waddr), 32'(q[0]));
            chk("wrap.mem_wdata", 32'(mem_wdata), 32'(q[0] + 8'h30));
            @(posedge clk);
            void'(q.pop_front());
            q.push_back(8'h33 + 8'(i));
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);
            #1;
            chk("wdrain.count",     32'(count),     32'(3 - i));
            chk("wdrain.mem_waddr", 32'(mem_waddr), 32'(q[0]));
            chk("wdrain.mem_wdata", 32'(mem_wdata), 32'(q[0] + 8'h30));
            @(posedge clk);
            void'(q.pop_front());
            @(negedge clk);
        end
        #1;
        chk("wdrain.empty", 32'(empty), 32'd1);

        // reset with pending entries discards them; drain requested during reset is ignored
        @(negedge clk);
        drive(1, 8'h40, 8'h80, 0, 8'h00, 8'h00, 0);
        @(posedge clk);
        @(negedge clk);
        drive(1, 8'h41, 8'h81, 0, 8'h00, 8'h00, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);
        #1;
        chk("prerst.count", 32'(count), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 8'h00, 8'h00, 1, 8'h40, 8'h77, 0);
        #1;
        chk("rst.count",    32'(count),    32'd0);
        chk("rst.empty",    32'(empty),    32'd1);
        chk("rst.mem_wen",  32'(mem_wen),  32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.mem_ren",  32'(mem_ren),  32'd1);
        chk("rst.in_rdata", 32'(in_rdata), 32'h77);
        @(posedge clk);
        @(negedge clk);
        drive(0, 8'h00, 8'h00, 1, 8'h41, 8'h78, 0);
        #1;
        chk("rst2.mem_ren",  32'(mem_ren),  32'd1);
        chk("rst2.in_rdata", 32'(in_rdata), 32'h78);
        chk("rst2.count",    32'(count),    32'd0);

        chk("protocol_errs", 32'(proto_errs), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vpipe_store_buffer.md
Name: vpipe_store_buffer

Overview:
- FIFO store buffer between the vpipe processor's memory write/read port and the abstract memory model downstream.
- Accepts STORE writes from the core, holds them in order, and drains them one per handshake into memory.
- Forwards buffered data to LOAD reads: the youngest matching entry wins, otherwise the read passes through to memory.
- Lets the team model a decoupled store path (STORE retires before memory commit) while preserving in-order memory semantics.

Parameters:
- AW, 8, address width in bits
- DW, 8, data width in bits
- DEPTH, 4, number of buffer entries; must be a power of two and >= 2
- PW, $clog2(DEPTH), pointer width (derived; not to be overridden)

Ports:
- clk  input  1  clock, all state updates on posedge
- rst  input  1  synchronous active-high reset
- in_wen  input  1  core write request (STORE)
- in_waddr  input  AW  core write address
- in_wdata  input  DW  core write data
- in_ready  output  1  buffer can accept a write this cycle
- in_ren  input  1  core read request (LOAD)
- in_raddr  input  AW  core read address
- in_rdata  output  DW  read data returned to core, combinational
- mem_wen  output  1  drain write valid to memory
- mem_waddr  output  AW  address of the head entry
- mem_wdata  output  DW  data of the head entry
- mem_wready  input  1  memory accepts the drain write this cycle
- mem_ren  output  1  read forwarded to memory (no buffer hit)
- mem_raddr  output  AW  equals in_raddr
- mem_rdata  input  DW  memory read data
- count  output  PW+1  number of occupied entries
- empty  output  1  count == 0

Behaviour:
- State: entry arrays addr[DEPTH], data[DEPTH], valid[DEPTH]; head and tail pointers (PW bits, natural wrap modulo DEPTH); count (PW+1 bits).
- Reset: head=0, tail=0, count=0, all valid=0. Outputs after reset: in_ready=1, mem_wen=0, empty=1, count=0. Entry addr/data contents are don't-care.
- Reset asserted mid-operation discards all pending entries on that edge. No drain occurs in the reset cycle.
- in_ready = (count != DEPTH). There is no full-bypass: when full, a write is refused even if a dequeue happens in the same cycle.
- Enqueue: in_wen && in_ready. Writes addr/data at tail, sets valid, and increments tail at the edge.
- A write while !in_ready is dropped. The bench flags it as a protocol error; the RTL is unchanged.
- Drain: mem_wen = !empty; mem_waddr/mem_wdata come from the head entry. Dequeue on mem_wen && mem_wready: clear valid[head], increment head.
- Drain latency: an entry enqueued at edge N is visible on mem_wen in cycle N+1 at the earliest, if the buffer was empty.
- count update: +1 on enqueue only, -1 on dequeue only, unchanged when both occur or neither. It never exceeds DEPTH and never underflows.
- Forwarding (combinational): search valid entries from youngest (tail-1) to oldest (head) for addr == in_raddr.
  - On hit, in_rdata = that entry's data and mem_ren = 0.
  - On miss with in_ren = 1, mem_ren = 1 and in_rdata = mem_rdata.
  - With in_ren = 0, mem_ren = 0 and in_rdata = 0.
- An entry being dequeued in the current cycle is still a forwarding candidate in that cycle.
- A write presented in the same cycle as a read is not forwarded. The read sees pre-write state, matching the core's read-before-write semantics.
- Multiple entries to the same address are kept separately, with no coalescing, and drain in program order.
- Wrap-around: pointers wrap from DEPTH-1 to 0. Full and empty are distinguished only by count.

Decomposition:
- Shared vpipe package/header holds the AW/DW defaults and the DEPTH power-of-two check constant.
- One combinational sub-module, vpipe_sb_fwd, takes the flattened valid/addr/data vectors, head, count and raddr. It returns hit and hit_data using a youngest-first priority search.
- FIFO control and pointer/count logic stay in the top module.

Test Plan:
- Reset then idle -> in_ready=1, empty=1, count=0, mem_wen=0 for 5 cycles.
- Write (0x10,0xAA) with mem_wready=0 -> next cycle count=1, mem_wen=1, mem_waddr=0x10, mem_wdata=0xAA. Raise mem_wready -> count=0 next cycle.
- mem_wready=0, write 4 entries (0x01..0x04 / 0x11..0x14) -> count=4, in_ready=0. A 5th write is refused and count stays 4. Then drain 4 with mem_wready=1 -> addresses emerge 0x01,0x02,0x03,0x04 in order.
- Buffer holds (0x20,0x05) then (0x20,0x07); read 0x20 -> in_rdata=0x07, mem_ren=0. Read 0x21 with mem_rdata=0x3C -> in_rdata=0x3C, mem_ren=1.
- Buffer has 3 entries; assert enqueue and dequeue in one cycle -> count stays 3. Run 10 cycles of this for pointer wrap -> drain order matches enqueue order.
- Buffer holds 2 entries; assert rst for one cycle -> next cycle count=0, empty=1, mem_wen=0. A read of a previously buffered address goes to memory (mem_ren=1).
